alu_iter: RTL and testbench

Parametrised multi-cycle successor of the single-cycle system ALU. It accepts an operation through a valid/ready handshake. All operations except division and remainder complete in one cycle. Division and remainder run on an iterative restoring divider, so no wide combinational divider is built. The block sits between the system controller (register-file operand fetch) and the result write-back path, in the reference clock domain, and is clock-gated externally when idle.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_divider.sv | 84 ++++++++
 rtl/alu_iter.sv | 150 +++++++++++++++
 tb/tb_alu_iter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the iterative system ALU.
//   - function-code constants ALU_ADD .. ALU_REM
//   - controller state enum (IDLE, DIV)
//   - result codes returned by the eq/gt/lt comparisons
package alu_pkg;

    localparam int unsigned ALU_ADD  = 0;
    localparam int unsigned ALU_SUB  = 1;
    localparam int unsigned ALU_MUL  = 2;
    localparam int unsigned ALU_DIV  = 3;
    localparam int unsigned ALU_AND  = 4;
    localparam int unsigned ALU_OR   = 5;
    localparam int unsigned ALU_NAND = 6;
    localparam int unsigned ALU_NOR  = 7;
    localparam int unsigned ALU_XOR  = 8;
    localparam int unsigned ALU_XNOR = 9;
    localparam int unsigned ALU_EQ   = 10;
    localparam int unsigned ALU_GT   = 11;
    localparam int unsigned ALU_LT   = 12;
    localparam int unsigned ALU_SHR  = 13;
    localparam int unsigned ALU_SHL  = 14;
    localparam int unsigned ALU_REM  = 15;

    localparam int unsigned CMP_EQ_RES = 1;
    localparam int unsigned CMP_GT_RES = 2;
    localparam int unsigned CMP_LT_RES = 3;

    typedef enum logic {
        IDLE = 1'b0,
        DIV  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_divider.sv
// alu_divider: serial restoring divider, one quotient bit per clock.
// Ports:
//   CLK, RST        clock, asynchronous active-low reset
//   start           load dividend/divisor and begin OP_WIDTH iterations
//   dividend        unsigned dividend (sampled on start)
//   divisor         unsigned divisor, must be non-zero (sampled on start)
//   done            high during the cycle whose edge performs the last step
//   quotient        result of the step taken at the coming edge
//   remainder       remainder after the step taken at the coming edge
// quotient/remainder are combinational views of the next step, so on the
// cycle where done is high they are the final results.
module alu_divider
    import alu_pkg::*;
#(
    parameter int OP_WIDTH = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [OP_WIDTH-1:0] dividend,
    input  logic [OP_WIDTH-1:0] divisor,
    output logic                done,
    output logic [OP_WIDTH-1:0] quotient,
    output logic [OP_WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(OP_WIDTH + 1);

    logic [CNT_W-1:0]    cnt_q;
    logic [OP_WIDTH-1:0] rem_q;
    logic [OP_WIDTH-1:0] quo_q;
    logic [OP_WIDTH-1:0] dvs_q;
    logic                active;

    logic [OP_WIDTH:0]   shifted;
    logic [OP_WIDTH:0]   diff;
    logic [OP_WIDTH-1:0] rem_d;
    logic [OP_WIDTH-1:0] quo_d;

    assign active = (cnt_q != '0);
    assign done   = (cnt_q == CNT_W'(1));

    // Iteration counter is control state and is cleared by reset, which
    // is what aborts a division in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= CNT_W'(OP_WIDTH);
        end else if (active) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // quo_q starts as the dividend and shifts left; dividend bits leave at
    // the top while quotient bits enter at the bottom.
    always_ff @(posedge CLK) begin
        if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (active) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    always_comb begin
        shifted = {rem_q, quo_q[OP_WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        // A clear borrow bit means the trial subtraction fits.
        if (!diff[OP_WIDTH]) begin
            rem_d = diff[OP_WIDTH-1:0];
            quo_d = {quo_q[OP_WIDTH-2:0], 1'b1};
        end else begin
            rem_d = shifted[OP_WIDTH-1:0];
            quo_d = {quo_q[OP_WIDTH-2:0], 1'b0};
        end
    end

    assign quotient  = quo_d;
    assign remainder = rem_d;

endmodule

// File: rtl/alu_iter.sv
// alu_iter: multi-cycle system ALU with valid/ready request handshake.
// Single-cycle ops complete at the accepting edge; div/rem run on the
// serial divider for OP_WIDTH cycles.
// Ports:
//   CLK, RST      clock, asynchronous active-low reset
//   IN_VALID      operation request
//   IN_READY      request can be accepted this cycle (IDLE)
//   A, B          unsigned operands
//   ALU_FUN       function code (see alu_pkg)
//   ALU_OUT       registered result, held until the next result
//   OUT_VALID     one-cycle pulse marking a new ALU_OUT
//   DIV_BY_ZERO   qualifies OUT_VALID for a div/rem issued with B==0
//   BUSY          divider iteration in progress
module alu_iter
    import alu_pkg::*;
#(
    parameter int OP_WIDTH  = 8,
    parameter int FUN_WIDTH = 4,
    parameter int OUT_WIDTH = 2 * OP_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [OP_WIDTH-1:0]  A,
    input  logic [OP_WIDTH-1:0]  B,
    input  logic [FUN_WIDTH-1:0] ALU_FUN,
    output logic [OUT_WIDTH-1:0] ALU_OUT,
    output logic                 OUT_VALID,
    output logic                 DIV_BY_ZERO,
    output logic                 BUSY
);

    alu_state_e state_q, state_d;

    logic [OUT_WIDTH-1:0] a_ext;
    logic [OUT_WIDTH-1:0] b_ext;
    logic [OUT_WIDTH-1:0] fast_res;
    logic                 is_divop;
    logic                 is_rem_op;
    logic                 accept;

    logic                 div_start;
    logic                 div_done;
    logic [OP_WIDTH-1:0]  div_quo;
    logic [OP_WIDTH-1:0]  div_rem;
    logic                 is_rem_q;

    logic [OUT_WIDTH-1:0] out_d;
    logic                 vld_d;
    logic                 dbz_d;

    assign a_ext     = OUT_WIDTH'(A);
    assign b_ext     = OUT_WIDTH'(B);
    assign is_rem_op = (ALU_FUN == FUN_WIDTH'(ALU_REM));
    assign is_divop  = (ALU_FUN == FUN_WIDTH'(ALU_DIV)) || is_rem_op;
    assign accept    = IN_VALID && (state_q == IDLE);
    assign IN_READY  = (state_q == IDLE);
    assign BUSY      = (state_q == DIV);

    // Single-cycle datapath. div/rem entries are the divide-by-zero results;
    // non-zero divisors take the iterative path instead.
    always_comb begin
        fast_res = '0;
        case (ALU_FUN)
            FUN_WIDTH'(ALU_ADD):  fast_res = a_ext + b_ext;
            FUN_WIDTH'(ALU_SUB):  fast_res = a_ext - b_ext;
            FUN_WIDTH'(ALU_MUL):  fast_res = a_ext * b_ext;
            FUN_WIDTH'(ALU_DIV):  fast_res = '1;
            FUN_WIDTH'(ALU_AND):  fast_res = a_ext & b_ext;
            FUN_WIDTH'(ALU_OR):   fast_res = a_ext | b_ext;
            FUN_WIDTH'(ALU_NAND): fast_res = ~(a_ext & b_ext);
            FUN_WIDTH'(ALU_NOR):  fast_res = ~(a_ext | b_ext);
            FUN_WIDTH'(ALU_XOR):  fast_res = a_ext ^ b_ext;
            FUN_WIDTH'(ALU_XNOR): fast_res = ~(a_ext ^ b_ext);
            FUN_WIDTH'(ALU_EQ):   fast_res = (A == B) ? OUT_WIDTH'(CMP_EQ_RES) : '0;
            FUN_WIDTH'(ALU_GT):   fast_res = (A > B)  ? OUT_WIDTH'(CMP_GT_RES) : '0;
            FUN_WIDTH'(ALU_LT):   fast_res = (A < B)  ? OUT_WIDTH'(CMP_LT_RES) : '0;
            FUN_WIDTH'(ALU_SHR):  fast_res = a_ext >> 1;
            FUN_WIDTH'(ALU_SHL):  fast_res = a_ext << 1;
            FUN_WIDTH'(ALU_REM):  fast_res = a_ext;
            default:              fast_res = '0;
        endcase
    end

    alu_divider #(
        .OP_WIDTH (OP_WIDTH)
    ) u_divider (
        .CLK       (CLK),
        .RST       (RST),
        .start     (div_start),
        .dividend  (A),
        .divisor   (B),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        state_d   = state_q;
        out_d     = ALU_OUT;
        vld_d     = 1'b0;
        dbz_d     = 1'b0;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_divop && (B != '0)) begin
                        div_start = 1'b1;
                        state_d   = DIV;
                    end else begin
                        out_d = fast_res;
                        vld_d = 1'b1;
                        dbz_d = is_divop;
                    end
                end
            end
            DIV: begin
                if (div_done) begin
                    out_d   = is_rem_q ? OUT_WIDTH'(div_rem) : OUT_WIDTH'(div_quo);
                    vld_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            ALU_OUT     <= '0;
            OUT_VALID   <= 1'b0;
            DIV_BY_ZERO <= 1'b0;
        end else begin
            state_q     <= state_d;
            ALU_OUT     <= out_d;
            OUT_VALID   <= vld_d;
            DIV_BY_ZERO <= dbz_d;
        end
    end

    // Remembers which result the running division should deliver.
    always_ff @(posedge CLK) begin
        if (div_start) begin
            is_rem_q <= is_rem_op;
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
module tb_alu_iter;

    logic        CLK;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_OUT;
    logic        OUT_VALID;
    logic        DIV_BY_ZERO;
    logic        BUSY;

    int total;
    int passed;
    int failed;

    alu_iter #(
        .OP_WIDTH  (8),
        .FUN_WIDTH (4),
        .OUT_WIDTH (16)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .A           (A),
        .B           (B),
        .ALU_FUN     (ALU_FUN),
        .ALU_OUT     (ALU_OUT),
        .OUT_VALID   (OUT_VALID),
        .DIV_BY_ZERO (DIV_BY_ZERO),
        .BUSY        (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request, let one edge accept it, then withdraw it.
    // Returns #1 after the accepting edge.
    task automatic issue(input logic [3:0] fun, input logic [7:0] a, input logic [7:0] b);
        ALU_FUN  = fun;
        A        = a;
        B        = b;
        IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    // Single-cycle op: result and pulse visible right after the accept edge.
    task automatic one_cycle(input string tag, input logic [3:0] fun,
                             input logic [7:0] a, input logic [7:0] b,
                             input logic [15:0] exp);
        issue(fun, a, b);
        check({tag, "_vld"}, 32'(OUT_VALID), 32'd1);
        check(tag, 32'(ALU_OUT), 32'(exp));
    endtask

    // Count edges until OUT_VALID, bounded; also count IN_READY-low cycles.
    task automatic wait_done(output int edges, output int low);
        edges = 0;
        low   = 0;
        while (edges < 20) begin
            @(posedge CLK);
            #1;
            edges++;
            if (OUT_VALID) break;
            if (!IN_READY) low++;
        end
    endtask

    int n;
    int lo;

    initial begin
        total    = 0;
        passed   = 0;
        failed   = 0;
        RST      = 1'b0;
        IN_VALID = 1'b0;
        A        = '0;
        B        = '0;
        ALU_FUN  = '0;

        repeat (2) @(posedge CLK);
        #1;
        check("rst_out",   32'(ALU_OUT),     32'h0);
        check("rst_vld",   32'(OUT_VALID),   32'd0);
        check("rst_dbz",   32'(DIV_BY_ZERO), 32'd0);
        check("rst_busy",  32'(BUSY),        32'd0);
        check("rst_ready", 32'(IN_READY),    32'd1);
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // Single-cycle operations
        one_cycle("add",  4'd0,  8'd200, 8'd100, 16'h012C);
        one_cycle("sub",  4'd1,  8'd3,   8'd5,   16'hFFFE);
        one_cycle("mul",  4'd2,  8'd255, 8'd255, 16'hFE01);
        one_cycle("shl",  4'd14, 8'h81,  8'h00,  16'h0102);
        one_cycle("nand", 4'd6,  8'hFF,  8'h0F,  16'hFFF0);
        one_cycle("gt",   4'd11, 8'd5,   8'd3,   16'h0002);
        one_cycle("lt",   4'd12, 8'd5,   8'd3,   16'h0000);
        one_cycle("eq",   4'd10, 8'd7,   8'd7,   16'h0001);
        one_cycle("xnor", 4'd9,  8'hF0,  8'h0F,  16'hFF00);
        one_cycle("shr",  4'd13, 8'h81,  8'h00,  16'h0040);
        check("lt_dbz", 32'(DIV_BY_ZERO), 32'd0);

        // Pulse drops and result holds on an idle edge
        @(posedge CLK);
        #1;
        check("idle_vld",  32'(OUT_VALID), 32'd0);
        check("idle_hold", 32'(ALU_OUT),   32'h0040);

        // div 200/7 with a rem request held through the division
        issue(4'd3, 8'd200, 8'd7);
        check("div_busy",  32'(BUSY),      32'd1);
        check("div_vld0",  32'(OUT_VALID), 32'd0);
        lo = (IN_READY == 1'b0) ? 1 : 0;
        ALU_FUN  = 4'd15;
        A        = 8'd200;
        B        = 8'd7;
        IN_VALID = 1'b1;
        wait_done(n, lo);
        check("div_lat",   32'(n),           32'd8);
        check("div_lowrd", 32'(lo + 1),      32'd8);
        check("div_res",   32'(ALU_OUT),     32'd28);
        check("div_dbz",   32'(DIV_BY_ZERO), 32'd0);
        check("div_ready", 32'(IN_READY),    32'd1);

        // Held rem is taken at the very next edge
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        check("rem_busy", 32'(BUSY),      32'd1);
        check("rem_vld0", 32'(OUT_VALID), 32'd0);
        wait_done(n, lo);
        check("rem_lat", 32'(n),       32'd8);
        check("rem_res", 32'(ALU_OUT), 32'd4);

        // Executed exactly once: no second run follows
        @(posedge CLK);
        #1;
        check("rem_once_vld", 32'(OUT_VALID), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        check("rem_once_busy", 32'(BUSY), 32'd0);

        // Division by zero
        issue(4'd3, 8'd9, 8'd0);
        check("dz_div_vld",  32'(OUT_VALID),   32'd1);
        check("dz_div_res",  32'(ALU_OUT),     32'hFFFF);
        check("dz_div_flag", 32'(DIV_BY_ZERO), 32'd1);
        check("dz_div_busy", 32'(BUSY),        32'd0);
        @(posedge CLK);
        #1;
        check("dz_clear", 32'(DIV_BY_ZERO), 32'd0);
        issue(4'd15, 8'd9, 8'd0);
        check("dz_rem_res",  32'(ALU_OUT),     32'h0009);
        check("dz_rem_flag", 32'(DIV_BY_ZERO), 32'd1);

        // Reset during a division
        issue(4'd3, 8'd200, 8'd7);
        repeat (3) @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        check("abort_out",   32'(ALU_OUT),   32'h0);
        check("abort_vld",   32'(OUT_VALID), 32'd0);
        check("abort_busy",  32'(BUSY),      32'd0);
        check("abort_ready", 32'(IN_READY),  32'd1);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        lo = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            if (OUT_VALID) lo++;
        end
        check("abort_no_vld", 32'(lo), 32'd0);
        one_cycle("post_add", 4'd0, 8'd1, 8'd2, 16'h0003);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
